ahb_slave_mem_responder: RTL and testbench
==========================================

Name: ahb_slave_mem_responder

Overview:
AHB-Lite slave memory that sits at the far end of the bus and answers transfers issued by the DMAC master interface. Channel transfers target it as source or destination: reads return stored words, writes update them. Configurable wait states and an out-of-range ERROR response let the DMAC readyIn/HResp handling be exercised. Word-only, single-port storage; it also accepts INCR bursts with BUSY/SEQ beats.

Parameters:
DEPTH, 256, number of 32-bit words stored; legal byte addresses are BASE_ADDR .. BASE_ADDR+4*DEPTH-1
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4*DEPTH aligned
WAIT_STATES, 0, data-phase wait cycles inserted before every OKAY completion (0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
HSel  input  1  slave select from decoder
HAddr  input  32  byte address (address phase)
HTrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWrite  input  1  1 = write transfer
HWData  input  32  write data (data phase)
HReady  input  1  bus ready (previous data phase complete)
HReadyOut  output  1  slave ready; 0 stretches the current data phase
HResp  output  2  OKAY=00, ERROR=01
HRData  output  32  read data, valid when HReadyOut=1 in a read data phase

Behaviour:
- Reset (rst=0, async): state IDLE, HReadyOut=1, HResp=OKAY, HRData=0, pending data phase cleared, wait counter 0. Memory contents are not reset.
- Address phase accept: HSel && HReady && HTrans[1]. On accept, latch write flag, word index (HAddr-BASE_ADDR)>>2, and error flag.
- Error flag: HAddr outside the legal range, or HAddr[1:0]!=0.
- Not selected, or IDLE/BUSY: no transfer. The next cycle is zero-wait OKAY and memory is untouched.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HReadyOut=1, HResp=OKAY.
    - Accept with error → ERR1.
    - Accept, no error, WAIT_STATES>0 → WAIT with counter=WAIT_STATES.
    - Accept, no error, WAIT_STATES=0 → stay IDLE; the data phase completes in the next cycle.
  - WAIT: HReadyOut=0, HResp=OKAY. Counter decrements each cycle. At counter==1 → IDLE, so the completion cycle has HReadyOut=1.
  - ERR1: HReadyOut=0, HResp=ERROR → ERR2.
  - ERR2: HReadyOut=1, HResp=ERROR. A new address may be accepted in this cycle (HReady=1) and follows the IDLE rules.
- Wait states apply only to OKAY transfers. An ERROR response always takes exactly 2 cycles.
- Writes: mem[idx] <= HWData at the clock edge ending a non-error write data phase (HReadyOut=1). No write for errored transfers.
- Reads:
  - HRData is registered from mem[idx]. Load at accept when WAIT_STATES=0; otherwise load on the final WAIT edge.
  - HRData holds its value until the next read load.
  - Errored reads drive HRData=0.
- Read-after-write hazard: a write data phase completes on the same edge that a read to the same index is loaded. HRData then takes HWData (forwarding), never the stale word.
- Back-to-back pipelining: a new address phase overlaps every completing data phase; sustained throughput is one word per (WAIT_STATES+1) cycles.
- BUSY inside a burst inserts zero-wait OKAY cycles. A following SEQ is accepted normally; the block does not check that SEQ addresses increment.
- Reset mid-transfer aborts the pending data phase. Any in-flight write is dropped.

Decomposition:
- Package ahb_pkg:
  - htrans_e (IDLE, BUSY, NONSEQ, SEQ)
  - HRESP_OKAY/HRESP_ERROR constants
  - resp_state_e (IDLE, WAIT, ERR1, ERR2)
  - AHB_DATA_W=32
  The DMAC master side shares this package.
- Sub-module ahb_sram_array (DEPTH×32):
  - synchronous write port (we, waddr, wdata)
  - combinational read port (raddr → rdata)
  The responder owns the FSM, counter, forwarding and HRData register.

Test Plan:
1. WAIT_STATES=0: NONSEQ write 0xDEADBEEF to 0x10, then NONSEQ read 0x10 → write completes with HReadyOut=1/OKAY; read data phase returns HRData=0xDEADBEEF, zero waits.
2. WAIT_STATES=3: single read of 0x20 preloaded with 0x12345678 → HReadyOut low for exactly 3 cycles, high on the 4th with OKAY and HRData=0x12345678.
3. DEPTH=256: write to 0x400 (out of range) and a read to 0x02 (misaligned) → each gives HReadyOut 0 then 1 with HResp=ERROR in both cycles; memory unchanged; HRData=0.
4. Pipelined write 0xA5A5A5A5 to 0x40 immediately followed by read 0x40 → read returns 0xA5A5A5A5 (forwarding), not the old value.
5. 4-beat INCR burst from DMAC model: NONSEQ 0x0, SEQ 0x4, BUSY, SEQ 0x8, SEQ 0xC, with writes 1,2,3,4 → BUSY cycle OKAY zero-wait; readback of 0x0..0xC returns 1..4.
6. Assert rst=0 during a WAIT-state write (WAIT_STATES=2) → immediately HReadyOut=1, HResp=OKAY, HRData=0; target word keeps its prior value after release.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions used by the DMAC master side and the memory responder.
package ahb_pkg;
    localparam int AHB_DATA_W = 32;
    localparam int AHB_ADDR_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_WAIT,
        RESP_ERR1,
        RESP_ERR2
    } resp_state_e;
endpackage

// File: rtl/ahb_sram_array.sv
// Word-wide storage: synchronous write port, combinational read port.
module ahb_sram_array
    import ahb_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [AHB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [AHB_DATA_W-1:0] rdata
);
    logic [AHB_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ahb_slave_mem_responder.sv
// AHB-Lite memory slave with programmable wait states and a two-cycle ERROR
// response for misaligned or out-of-range addresses.
module ahb_slave_mem_responder
    import ahb_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSel,
    input  logic [AHB_ADDR_W-1:0] HAddr,
    input  logic [1:0]            HTrans,
    input  logic                  HWrite,
    input  logic [AHB_DATA_W-1:0] HWData,
    input  logic                  HReady,
    output logic                  HReadyOut,
    output logic [1:0]            HResp,
    output logic [AHB_DATA_W-1:0] HRData
);
    localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AHB_ADDR_W-1:0] SPAN      = AHB_ADDR_W'(4 * DEPTH);
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);
    localparam bit                    ZERO_WAIT = (WAIT_STATES == 0);

    resp_state_e           state, state_next;
    logic [3:0]            wait_cnt, wait_cnt_next;
    logic                  dp_valid, dp_write;
    logic [IDX_W-1:0]      dp_idx;
    htrans_e               trans;
    logic [AHB_ADDR_W-1:0] offset;
    logic [IDX_W-1:0]      acc_idx, rd_idx;
    logic                  addr_err, accept, we, load_read, load_zero;
    logic [AHB_DATA_W-1:0] mem_rdata, read_word;

    // Below-base addresses wrap to a huge offset, so one compare covers both ends.
    assign trans    = htrans_e'(HTrans);
    assign offset   = HAddr - BASE_ADDR;
    assign addr_err = (offset >= SPAN) || (HAddr[1:0] != 2'b00);
    assign acc_idx  = offset[IDX_W+1:2];
    assign accept   = HSel && HReady && HReadyOut &&
                      (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

    assign we = dp_valid && dp_write && HReadyOut;

    // A write retiring on the same edge as a read load must be forwarded.
    assign rd_idx    = ZERO_WAIT ? acc_idx : dp_idx;
    assign read_word = (we && dp_idx == rd_idx) ? HWData : mem_rdata;
    assign load_read = ZERO_WAIT ? (accept && !addr_err && !HWrite)
                                 : (state == RESP_WAIT && wait_cnt == 4'd1 && !dp_write);
    assign load_zero = accept && addr_err && !HWrite;

    ahb_sram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (dp_idx),
        .wdata (HWData),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        HReadyOut     = 1'b1;
        HResp         = HRESP_OKAY;
        case (state)
            RESP_IDLE, RESP_ERR2: begin
                if (state == RESP_ERR2) begin
                    HResp = HRESP_ERROR;
                end
                state_next = RESP_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_next = RESP_ERR1;
                    end else if (!ZERO_WAIT) begin
                        state_next    = RESP_WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end
                end
            end
            RESP_WAIT: begin
                HReadyOut     = 1'b0;
                wait_cnt_next = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_next = RESP_IDLE;
                end
            end
            RESP_ERR1: begin
                HReadyOut  = 1'b0;
                HResp      = HRESP_ERROR;
                state_next = RESP_ERR2;
            end
            default: state_next = RESP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RESP_IDLE;
            wait_cnt <= 4'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            HRData   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (HReadyOut) begin
                dp_valid <= accept && !addr_err;
                if (accept) begin
                    dp_write <= HWrite;
                    dp_idx   <= acc_idx;
                end
            end
            if (load_zero) begin
                HRData <= '0;
            end else if (load_read) begin
                HRData <= read_word;
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_mem_responder.sv
// Scoreboard bench: the driver queues the expected response of every transfer,
// a negedge monitor retires them as data phases complete.
module tb_ahb_slave_mem_responder;
    import ahb_pkg::*;

    typedef struct {
        int          id;
        logic        is_read;
        logic [1:0]  resp;
        int          waits;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel_bus, hwrite;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata;
    int          active;
    logic [2:0]  sel_vec, ready_vec;
    logic [1:0]  resp_vec [3];
    logic [31:0] rdata_vec [3];
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q [$];
    exp_t        cur;
    logic        pending = 1'b0;
    int          wait_seen = 0;
    logic [31:0] next_wdata = 32'h0;
    int          next_id = 0;

    always #5 clk = ~clk;

    assign sel_vec = hsel_bus ? (3'b001 << active) : 3'b000;

    always_comb begin
        case (active)
            0: begin hready = ready_vec[0]; hresp = resp_vec[0]; hrdata = rdata_vec[0]; end
            1: begin hready = ready_vec[1]; hresp = resp_vec[1]; hrdata = rdata_vec[1]; end
            default: begin hready = ready_vec[2]; hresp = resp_vec[2]; hrdata = rdata_vec[2]; end
        endcase
    end

    ahb_slave_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst), .HSel(sel_vec[0]), .HAddr(haddr), .HTrans(htrans),
        .HWrite(hwrite), .HWData(hwdata), .HReady(ready_vec[0]),
        .HReadyOut(ready_vec[0]), .HResp(resp_vec[0]), .HRData(rdata_vec[0]));

    ahb_slave_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .rst(rst), .HSel(sel_vec[1]), .HAddr(haddr), .HTrans(htrans),
        .HWrite(hwrite), .HWData(hwdata), .HReady(ready_vec[1]),
        .HReadyOut(ready_vec[1]), .HResp(resp_vec[1]), .HRData(rdata_vec[1]));

    ahb_slave_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .rst(rst), .HSel(sel_vec[2]), .HAddr(haddr), .HTrans(htrans),
        .HWrite(hwrite), .HWData(hwdata), .HReady(ready_vec[2]),
        .HReadyOut(ready_vec[2]), .HResp(resp_vec[2]), .HRData(rdata_vec[2]));

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one address phase (plus the write data of the previous transfer)
    // and holds it until the bus is ready.
    task automatic apply_stimulus(input logic sel, input logic [1:0] trans, input logic write,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  input logic [1:0] resp, input int waits,
                                  input logic [31:0] rdata);
        exp_t e;
        logic ready_seen;
        int   guard;
        hsel_bus   = sel;
        htrans     = trans;
        hwrite     = write;
        haddr      = addr;
        hwdata     = next_wdata;
        next_wdata = 32'h0;
        if (sel && trans[1]) begin
            e.id      = next_id;
            e.is_read = !write;
            e.resp    = resp;
            e.waits   = waits;
            e.rdata   = rdata;
            exp_q.push_back(e);
            next_id++;
            if (write) next_wdata = data;
        end
        ready_seen = 1'b0;
        guard = 0;
        while (!ready_seen && guard < 64) begin
            @(negedge clk);
            ready_seen = hready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ready_seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL bus_stall: HReadyOut stuck at %b, expected 1", hready);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [1:0] resp, input int waits);
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, addr, data, resp, waits, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [1:0] resp, input int waits,
                      input logic [31:0] rdata);
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, addr, 32'h0, resp, waits, rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'h0, HRESP_OKAY, 0, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pending   = 1'b0;
            wait_seen = 0;
        end else begin
            if (pending) begin
                if (!hready) begin
                    check_output($sformatf("t%0d_wait_resp", cur.id), {30'd0, hresp}, {30'd0, cur.resp});
                    wait_seen++;
                    if (wait_seen > 40) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL t%0d_timeout: waits %0d, expected %0d", cur.id, wait_seen, cur.waits);
                        pending = 1'b0;
                    end
                end else begin
                    check_output($sformatf("t%0d_resp", cur.id), {30'd0, hresp}, {30'd0, cur.resp});
                    check_output($sformatf("t%0d_waits", cur.id), 32'(wait_seen), 32'(cur.waits));
                    if (cur.is_read) begin
                        check_output($sformatf("t%0d_rdata", cur.id), hrdata, cur.rdata);
                    end
                    pending = 1'b0;
                end
            end else begin
                check_output("idle_ready_resp", {29'd0, hready, hresp}, {29'd0, 1'b1, HRESP_OKAY});
            end
            if (hsel_bus && hready && htrans[1]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_xfer: addr %h accepted, expected none", haddr);
                end else begin
                    cur       = exp_q.pop_front();
                    pending   = 1'b1;
                    wait_seen = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        hsel_bus = 1'b0;
        htrans   = HTRANS_IDLE;
        hwrite   = 1'b0;
        haddr    = 32'h0;
        hwdata   = 32'h0;
        active   = 0;
        rst      = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ready", {31'd0, hready}, 32'd1);
        check_output("reset_resp", {30'd0, hresp}, {30'd0, HRESP_OKAY});
        check_output("reset_rdata", hrdata, 32'h0);
        rst = 1'b1;
        idle(2);

        // Zero-wait write then pipelined read of the same word.
        wr(32'h10, 32'hDEADBEEF, HRESP_OKAY, 0);
        rd(32'h10, HRESP_OKAY, 0, 32'hDEADBEEF);
        idle(1);

        // Read-after-write forwarding over an older value.
        wr(32'h40, 32'h0BAD0BAD, HRESP_OKAY, 0);
        idle(1);
        wr(32'h40, 32'hA5A5A5A5, HRESP_OKAY, 0);
        rd(32'h40, HRESP_OKAY, 0, 32'hA5A5A5A5);
        idle(1);
        rd(32'h40, HRESP_OKAY, 0, 32'hA5A5A5A5);
        idle(1);

        // Out-of-range write and misaligned read; word 0 aliases 0x400 if range is ignored.
        wr(32'h0, 32'h11111111, HRESP_OKAY, 0);
        wr(32'h400, 32'hBAD0BAD0, HRESP_ERROR, 1);
        rd(32'h02, HRESP_ERROR, 1, 32'h0);
        rd(32'h0, HRESP_OKAY, 0, 32'h11111111);
        idle(1);

        // INCR burst with a BUSY beat, then readback.
        apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, 32'h0, 32'd1, HRESP_OKAY, 0, 32'h0);
        apply_stimulus(1'b1, HTRANS_SEQ,    1'b1, 32'h4, 32'd2, HRESP_OKAY, 0, 32'h0);
        apply_stimulus(1'b1, HTRANS_BUSY,   1'b1, 32'h8, 32'd0, HRESP_OKAY, 0, 32'h0);
        apply_stimulus(1'b1, HTRANS_SEQ,    1'b1, 32'h8, 32'd3, HRESP_OKAY, 0, 32'h0);
        apply_stimulus(1'b1, HTRANS_SEQ,    1'b1, 32'hC, 32'd4, HRESP_OKAY, 0, 32'h0);
        idle(1);
        rd(32'h0, HRESP_OKAY, 0, 32'd1);
        rd(32'h4, HRESP_OKAY, 0, 32'd2);
        rd(32'h8, HRESP_OKAY, 0, 32'd3);
        rd(32'hC, HRESP_OKAY, 0, 32'd4);
        idle(2);

        // Three wait states.
        active = 1;
        wr(32'h20, 32'h12345678, HRESP_OKAY, 3);
        idle(1);
        rd(32'h20, HRESP_OKAY, 3, 32'h12345678);
        wr(32'h24, 32'hCAFEF00D, HRESP_OKAY, 3);
        rd(32'h24, HRESP_OKAY, 3, 32'hCAFEF00D);
        idle(2);

        // Reset in the middle of a two-wait write.
        active = 2;
        wr(32'h30, 32'h55AA55AA, HRESP_OKAY, 2);
        idle(1);
        rd(32'h30, HRESP_OKAY, 2, 32'h55AA55AA);
        idle(1);
        hsel_bus = 1'b1;
        htrans   = HTRANS_NONSEQ;
        hwrite   = 1'b1;
        haddr    = 32'h30;
        hwdata   = 32'h0;
        exp_q.push_back('{id: next_id, is_read: 1'b0, resp: HRESP_OKAY, waits: 2, rdata: 32'h0});
        next_id++;
        @(posedge clk);
        #1;
        hsel_bus = 1'b0;
        htrans   = HTRANS_IDLE;
        hwrite   = 1'b0;
        hwdata   = 32'hFFFF0000;
        #2 rst = 1'b0;
        #1;
        check_output("midreset_ready", {31'd0, hready}, 32'd1);
        check_output("midreset_resp", {30'd0, hresp}, {30'd0, HRESP_OKAY});
        check_output("midreset_rdata", hrdata, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        hwdata = 32'h0;
        idle(1);
        rd(32'h30, HRESP_OKAY, 2, 32'h55AA55AA);
        idle(3);

        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
